ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 keyboard receiver with scancode buffering. Deserialises device-to-host frames from the raw ps2_clk/ps2_dat lines, validates them, and queues good bytes in a small FIFO. It sits directly upstream of the keyboard matrix mapper, which consumes bytes through the dsr/rden/q strobe interface. Buffering lets a multi-byte sequence such as E0 F0 75 arrive while the mapper is busy.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2.
FILTER, 8, consecutive identical samples needed before the filtered ps2_clk changes level.
TIMEOUT_CYCLES, 20000, clkk cycles without a falling edge mid-frame before the frame is abandoned.

Ports:
clkk  in  1  system clock; the only clock.
reset_n  in  1  asynchronous, active-low reset.
ps2_clk  in  1  raw PS/2 clock line, asynchronous to clkk.
ps2_dat  in  1  raw PS/2 data line, asynchronous to clkk.
rden  in  1  read strobe, one clkk cycle wide.
q  out  8  last byte read; held until the next accepted rden.
dsr  out  1  data set ready; high while the FIFO is non-empty.
frame_err  out  1  one-cycle pulse on a rejected frame.
overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: q=00, dsr=0, frame_err=0, overflow=0, level=0.
  - Internal: FIFO pointers=0, receiver in IDLE, sync and filter registers=1, timeout counter=0.
  - Reset asserted mid-frame discards the partial frame; no error pulse.
- Input conditioning:
  - Both lines pass a 2-flop synchroniser.
  - ps2_clk additionally passes a FILTER-sample stability filter.
  - A falling edge is the filtered clock going 1->0.
  - ps2_dat is sampled from its synchronised copy in the same cycle as that edge.
- Receiver FSM (advances only on falling edges, except for timeout):
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> remain in IDLE; this is a false start and is not an error.
  - DATA: shift in LSB first, bitcnt+1. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: the frame is good if the stop bit is 1 AND the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Good frame -> push request.
    - Bad frame -> frame_err pulse, byte discarded.
    - Either way -> IDLE.
  - Timeout: in DATA, PARITY or STOP, the counter increments every clkk and clears on each falling edge. When it reaches TIMEOUT_CYCLES: frame_err pulse, -> IDLE, partial byte discarded. The counter is held at 0 in IDLE.
- Push timing: the push request is asserted in the cycle after the stop-bit edge; the byte is in the FIFO one cycle after that.
- FIFO:
  - Circular buffer with wrapping pointers.
  - level = write count - read count, range 0..DEPTH.
  - dsr = (level != 0), registered together with level.
  - Write: accepted if level<DEPTH, or if level==DEPTH and an accepted rden occurs in the same cycle (level then unchanged).
  - Otherwise the byte is dropped and overflow pulses; existing contents are unchanged.
- Read:
  - rden with dsr=1: q <= head entry at that clock edge, read pointer advances, level decrements.
  - q is valid from the cycle after rden and stays stable until the next accepted rden.
  - rden with dsr=0: ignored; q and pointers unchanged.
  - rden held high for consecutive cycles reads one byte per cycle while dsr=1.
- Simultaneous push and read when level=0: the read is ignored, because the byte is not yet visible; the write proceeds and dsr rises in the following cycle.
- Pointer wrap-around after DEPTH writes must preserve order. Ordering is strictly FIFO.
- No output has a combinational path from ps2_clk, ps2_dat or rden.

Test Plan:
1. Single frame, byte 1C (odd parity bit=0, stop=1), ~12 kHz PS/2 clock -> dsr rises at most 2 cycles after the stop-bit edge. Pulse rden -> next cycle q=1C, dsr=0, level=0.
2. Back-to-back frames E0, F0, 75 with no reads -> level=3. Three rden pulses spaced 4 cycles apart -> q reads E0, F0, 75 in order, each stable between strobes.
3. Frame 1C with parity bit=1 -> frame_err pulses once, level stays 0. Separately, a frame with stop bit=0 -> frame_err, nothing queued.
4. Clock stops after 4 data bits; wait TIMEOUT_CYCLES -> frame_err pulses once, FSM in IDLE. A following good frame 5A is received correctly as 5A.
5. Send DEPTH+1 good frames 01..09 (DEPTH=8) without reading -> level=8, one overflow pulse on byte 09. Reads return 01..08; a further rden with dsr=0 leaves q=08.
6. Two edge cases:
   - Assert reset_n low mid-frame, then release and send 29 -> q=29 after read; no frame_err across reset.
   - Glitch of FILTER-1 cycles on ps2_clk -> no bit is shifted.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: 2-flop sync, clock glitch filter, frame FSM, byte FIFO.
// Latency: byte visible (dsr high) two clkk cycles after the filtered stop-bit falling edge.
// Backpressure: none toward the device; a good byte arriving when full is dropped with an overflow pulse.
module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int FILTER         = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                       clkk,
    input  logic                       reset_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_dat,
    input  logic                       rden,
    output logic [7:0]                 q,
    output logic                       dsr,
    output logic                       frame_err,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int FCW = $clog2(FILTER + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ---------------- input conditioning ----------------
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall;

    // Two-flop synchronisers for both raw lines; idle level is high.
    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock only follows the synchronised clock after FILTER consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    // The edge is seen in the cycle the filtered level is about to drop, so data is sampled alongside it.
    assign fall = filt_q & ~filt_d;

    // ---------------- frame receiver ----------------
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          push_q, push_d;
    logic [7:0]    push_dat_q, push_dat_d;
    logic          ferr_q, ferr_d;

    // Frame FSM advances on filtered falling edges; the watchdog abandons a stalled frame.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tcnt_d     = '0;
        push_d     = 1'b0;
        push_dat_d = push_dat_q;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A high data line at a falling edge is a false start, silently ignored.
                if (fall && !dat_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                        push_d     = 1'b1;
                        push_dat_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && !fall) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                ferr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Receiver and filter state registers.
    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            push_q     <= 1'b0;
            push_dat_q <= 8'h00;
            ferr_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            ferr_q     <= ferr_d;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]    mem_q [DEPTH];
    logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          dsr_q, dsr_d;
    logic [7:0]    q_q, q_d;
    logic          ovf_q, ovf_d;
    logic          rd_acc, wr_acc;

    // A read is only honoured on a visible byte; a write into a full FIFO needs a same-cycle read to make room.
    always_comb begin
        rd_acc   = rden & dsr_q;
        wr_acc   = push_q & ((level_q < LW'(DEPTH)) | rd_acc);
        ovf_d    = push_q & ~wr_acc;
        wr_ptr_d = wr_ptr_q + LW'(wr_acc);
        rd_ptr_d = rd_ptr_q + LW'(rd_acc);
        level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
        dsr_d    = (level_d != '0);
        q_d      = rd_acc ? mem_q[rd_ptr_q[PW-1:0]] : q_q;
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clkk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_dat_q;
        end
    end

    // FIFO pointers, occupancy and registered outputs.
    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dsr_q    <= 1'b0;
            q_q      <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dsr_q    <= dsr_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q         = q_q;
    assign dsr       = dsr_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;
    assign level     = level_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, parity/stop errors, timeout, overflow, reset and glitch cases.
// PS/2 bit rate is scaled up relative to clkk (and the timeout shortened) to keep the run short.
// Expected values are hand-computed constants in the stimulus below.
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int FILTER  = 8;
    localparam int TMO     = 400;
    localparam int H       = 40;

    logic       clkk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rden = 1'b0;
    logic [7:0] q;
    logic       dsr;
    logic       frame_err;
    logic       overflow;
    logic [3:0] level;

    int n_cmp = 0;
    int n_mis = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    int lat;
    int e0;
    int o0;

    ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT_CYCLES(TMO)) dut (
        .clkk      (clkk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rden      (rden),
        .q         (q),
        .dsr       (dsr),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clkk = ~clkk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clkk) begin
        if (frame_err) n_ferr++;
        if (overflow)  n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkk);
        #1;
    endtask

    // Sends the first nbits of a frame (11 = full frame); optional parity / stop corruption.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        logic [3:0]  lvl0;
        bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        lvl0 = level;
        lat  = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            for (int k = 0; k < H; k++) begin
                tick(1);
                if (i == 10 && lat < 0 && level != lvl0) lat = k + 1;
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(H);
    endtask

    task automatic read_byte();
        rden = 1'b1;
        tick(1);
        rden = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(5);
        check("rst_q", q, 8'h00);
        check("rst_dsr", dsr, 1'b0);
        check("rst_lvl", level, 4'd0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        tick(5);

        // 1: single frame 1C
        e0 = n_ferr;
        send_frame(8'h1C, 0, 0, 11);
        check("t1_lat_ok", (lat >= 1 && lat <= FILTER + 4), 1'b1);
        check("t1_dsr", dsr, 1'b1);
        check("t1_lvl", level, 4'd1);
        read_byte();
        check("t1_q", q, 8'h1C);
        check("t1_dsr0", dsr, 1'b0);
        check("t1_lvl0", level, 4'd0);
        check("t1_noerr", n_ferr - e0, 0);

        // 2: E0 F0 75 queued, read out with spaced strobes
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);
        check("t2_lvl", level, 4'd3);
        read_byte();
        check("t2_q0", q, 8'hE0);
        tick(3);
        check("t2_q0_hold", q, 8'hE0);
        read_byte();
        check("t2_q1", q, 8'hF0);
        tick(3);
        check("t2_q1_hold", q, 8'hF0);
        read_byte();
        check("t2_q2", q, 8'h75);
        check("t2_dsr0", dsr, 1'b0);

        // 3: bad parity, then bad stop bit
        e0 = n_ferr;
        send_frame(8'h1C, 1, 0, 11);
        check("t3_par_err", n_ferr - e0, 1);
        check("t3_par_lvl", level, 4'd0);
        send_frame(8'h1C, 0, 1, 11);
        check("t3_stop_err", n_ferr - e0, 2);
        check("t3_stop_lvl", level, 4'd0);

        // 4: clock stops after 4 data bits -> timeout, then good 5A
        e0 = n_ferr;
        send_frame(8'h5A, 0, 0, 5);
        tick(TMO + 20);
        check("t4_tmo_err", n_ferr - e0, 1);
        check("t4_tmo_lvl", level, 4'd0);
        send_frame(8'h5A, 0, 0, 11);
        check("t4_lvl", level, 4'd1);
        read_byte();
        check("t4_q", q, 8'h5A);
        check("t4_noerr", n_ferr - e0, 1);

        // 5: overflow with DEPTH+1 frames
        o0 = n_ovf;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 11);
        check("t5_lvl", level, 4'd8);
        check("t5_ovf", n_ovf - o0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            read_byte();
            check($sformatf("t5_q%0d", i), q, 32'(i));
        end
        check("t5_dsr0", dsr, 1'b0);
        read_byte();
        check("t5_q_hold", q, 8'h08);
        check("t5_lvl0", level, 4'd0);

        // 6a: reset mid-frame, then 29
        e0 = n_ferr;
        send_frame(8'h55, 0, 0, 4);
        reset_n = 1'b0;
        tick(3);
        check("t6_rst_q", q, 8'h00);
        reset_n = 1'b1;
        tick(TMO + 20);
        check("t6_rst_noerr", n_ferr - e0, 0);
        check("t6_rst_lvl", level, 4'd0);
        send_frame(8'h29, 0, 0, 11);
        read_byte();
        check("t6_q29", q, 8'h29);
        check("t6_noerr", n_ferr - e0, 0);

        // 6b: FILTER-1 cycle glitch on ps2_clk with data low must not start a frame
        ps2_dat = 1'b0;
        tick(H);
        ps2_clk = 1'b0;
        tick(FILTER - 1);
        ps2_clk = 1'b1;
        tick(H);
        ps2_dat = 1'b1;
        tick(H);
        send_frame(8'h3C, 0, 0, 11);
        check("t6_glitch_lvl", level, 4'd1);
        read_byte();
        check("t6_glitch_q", q, 8'h3C);
        check("t6_glitch_noerr", n_ferr - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
